// File: rtl/fft_ctrl_pkg.sv
// Shared constants and state encoding for the 2-D FFT sequencer.
// PipeLatDefault comes from the datapath team so both sides agree on the latency.
package fft_ctrl_pkg;

    localparam int unsigned N              = 64;
    localparam int unsigned IdxW           = 6;
    localparam int unsigned PipeLatDefault = 12;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRowIssue,
        StRowDrain,
        StColIssue,
        StColDrain,
        StDone
    } state_e;

endpackage

// File: rtl/fft_valid_tracker.sv
// Follows issued vectors through the fixed-latency datapath and numbers the results.
// Results leave in issue order, so a plain counter supplies the write index.
module fft_valid_tracker
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned PipeLat = PipeLatDefault
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            issue_i,
    output logic            wr_en_o,
    output logic [IdxW-1:0] wr_idx_o
);

    logic [PipeLat-1:0] valid_q, valid_d;
    logic [IdxW-1:0]    wr_idx_q, wr_idx_d;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = issue_i;
        wr_idx_d   = wr_idx_q;
        if (wr_en_o) begin
            wr_idx_d = wr_idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q  <= '0;
            wr_idx_q <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    assign wr_en_o  = valid_q[PipeLat-1];
    assign wr_idx_o = wr_idx_q;

endmodule

// File: rtl/fft_2d_controller.sv
// Sequences a 64x64 2-D FFT as a row pass then a column pass through one 64-point datapath.
// Each pass is fully drained before the next starts, so columns only see finished rows.
module fft_2d_controller
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned PipeLat = PipeLatDefault
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            hold_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [IdxW-1:0] rd_idx_o,
    output logic            fft_valid_in_o,
    output logic            pass_col_o,
    output logic            wr_en_o,
    output logic [IdxW-1:0] wr_idx_o
);

    state_e          state_q, state_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic            pass_col_q, pass_col_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            issue;
    logic            wr_en;
    logic [IdxW-1:0] wr_idx;
    logic            last_wr;

    assign last_wr = wr_en && (wr_idx == LastIdx);

    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        pass_col_d = pass_col_q;
        issue      = 1'b0;

        unique case (state_q)
            StIdle: begin
                pass_col_d = 1'b0;
                if (start_i) begin
                    state_d = StRowIssue;
                end
            end
            StRowIssue: begin
                if (!hold_i) begin
                    issue    = 1'b1;
                    rd_idx_d = rd_idx_q + IdxW'(1);
                    if (rd_idx_q == LastIdx) begin
                        state_d = StRowDrain;
                    end
                end
            end
            StRowDrain: begin
                if (last_wr) begin
                    state_d    = StColIssue;
                    pass_col_d = 1'b1;
                end
            end
            StColIssue: begin
                if (!hold_i) begin
                    issue    = 1'b1;
                    rd_idx_d = rd_idx_q + IdxW'(1);
                    if (rd_idx_q == LastIdx) begin
                        state_d = StColDrain;
                    end
                end
            end
            StColDrain: begin
                if (last_wr) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d    = StIdle;
                pass_col_d = 1'b0;
            end
            default: begin
                state_d    = StIdle;
                pass_col_d = 1'b0;
            end
        endcase

        // Registered flags: busy drops and done pulses together, the cycle after StDone.
        busy_d = (state_d != StIdle);
        done_d = (state_q == StDone);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rd_idx_q   <= '0;
            pass_col_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            pass_col_q <= pass_col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    fft_valid_tracker #(
        .PipeLat (PipeLat)
    ) u_tracker (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .issue_i  (issue),
        .wr_en_o  (wr_en),
        .wr_idx_o (wr_idx)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign rd_en_o        = issue;
    assign fft_valid_in_o = issue;
    assign rd_idx_o       = rd_idx_q;
    assign pass_col_o     = pass_col_q;
    assign wr_en_o        = wr_en;
    assign wr_idx_o       = wr_idx;

endmodule

// File: tb/tb_fft_2d_controller.sv
// Bench for fft_2d_controller: three instances (latency 12, 1, 63) share clock, reset and hold,
// each with its own start; observed events are compared against a frame-level timeline model.
module tb_fft_2d_controller;

    localparam int NV   = 64;
    localparam int MaxC = 16384;

    typedef struct packed {
        int dut;
        int kind;  // 0 read issue, 1 write, 2 done pulse, 3 busy edge
        int cyc;
        int idx;
        int pc;
        int fv;
    } ev_t;

    logic       clk     = 1'b0;
    logic       reset_i = 1'b1;
    logic       hold_i  = 1'b0;
    logic       start_w    [3];
    logic       busy_w     [3];
    logic       done_w     [3];
    logic       rd_en_w    [3];
    logic [5:0] rd_idx_w   [3];
    logic       fv_w       [3];
    logic       pc_w       [3];
    logic       wr_en_w    [3];
    logic [5:0] wr_idx_w   [3];
    logic       prev_busy  [3];

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  lat_tab [3];
    bit  hold_at [MaxC];
    bit  start_at [3][MaxC];
    ev_t got_q [$];
    ev_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_2d_controller #(.PipeLat(12)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_w[0]), .hold_i(hold_i),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .rd_en_o(rd_en_w[0]), .rd_idx_o(rd_idx_w[0]),
        .fft_valid_in_o(fv_w[0]), .pass_col_o(pc_w[0]), .wr_en_o(wr_en_w[0]),
        .wr_idx_o(wr_idx_w[0])
    );
    fft_2d_controller #(.PipeLat(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_w[1]), .hold_i(hold_i),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .rd_en_o(rd_en_w[1]), .rd_idx_o(rd_idx_w[1]),
        .fft_valid_in_o(fv_w[1]), .pass_col_o(pc_w[1]), .wr_en_o(wr_en_w[1]),
        .wr_idx_o(wr_idx_w[1])
    );
    fft_2d_controller #(.PipeLat(63)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_w[2]), .hold_i(hold_i),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .rd_en_o(rd_en_w[2]), .rd_idx_o(rd_idx_w[2]),
        .fft_valid_in_o(fv_w[2]), .pass_col_o(pc_w[2]), .wr_en_o(wr_en_w[2]),
        .wr_idx_o(wr_idx_w[2])
    );

    function automatic ev_t mk(int d, int k, int c, int i, int p, int f);
        ev_t e;
        e.dut = d; e.kind = k; e.cyc = c; e.idx = i; e.pc = p; e.fv = f;
        return e;
    endfunction

    // Outputs sampled mid-cycle; cycle label = posedges seen so far.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rd_en_w[d] || fv_w[d])
                got_q.push_back(mk(d, 0, cyc, int'(rd_idx_w[d]), int'(pc_w[d]),
                                   int'({rd_en_w[d], fv_w[d]})));
            if (wr_en_w[d])
                got_q.push_back(mk(d, 1, cyc, int'(wr_idx_w[d]), int'(pc_w[d]), 0));
            if (done_w[d])
                got_q.push_back(mk(d, 2, cyc, 0, 0, 0));
            if (busy_w[d] !== prev_busy[d])
                got_q.push_back(mk(d, 3, cyc, int'(busy_w[d]), 0, 0));
            prev_busy[d] <= busy_w[d];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        hold_i = hold_at[cyc];
        for (int d = 0; d < 3; d++) start_w[d] = start_at[d][cyc];
    endtask

    // mode 0: no hold, 1: hold on odd cycles, 2: random hold about a quarter of the time
    task automatic set_hold(input int mode, input int from);
        for (int c = from; c < from + 1500; c++) begin
            case (mode)
                1:       hold_at[c] = (c % 2) == 1;
                2:       hold_at[c] = ($urandom_range(0, 3) == 0);
                default: hold_at[c] = 1'b0;
            endcase
        end
    endtask

    // Frame timeline from start driven in cycle s: issues fill non-held cycles, each result
    // appears lat cycles later, columns start the cycle after the last row result, done two
    // cycles after the last column result.
    task automatic model_frame(input int d, input int s, output int done_c);
        int t;
        int n;
        int wlast;
        int lat;
        lat   = lat_tab[d];
        wlast = 0;
        exp_q.push_back(mk(d, 3, s + 1, 1, 0, 0));
        t = s + 1;
        for (int p = 0; p < 2; p++) begin
            n = 0;
            while (n < NV) begin
                if (!hold_at[t]) begin
                    exp_q.push_back(mk(d, 0, t, n, p, 3));
                    exp_q.push_back(mk(d, 1, t + lat, n, p, 0));
                    wlast = t + lat;
                    n++;
                end
                t++;
            end
            t = wlast + 1;
        end
        done_c = wlast + 2;
        exp_q.push_back(mk(d, 2, done_c, 0, 0, 0));
        exp_q.push_back(mk(d, 3, done_c, 0, 0, 0));
    endtask

    task automatic check_all(input string tag);
        ev_t gq [$];
        ev_t eq [$];
        int  m;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                gq.delete();
                eq.delete();
                foreach (got_q[i]) if (got_q[i].dut == d && got_q[i].kind == k) gq.push_back(got_q[i]);
                foreach (exp_q[i]) if (exp_q[i].dut == d && exp_q[i].kind == k) eq.push_back(exp_q[i]);
                n_cmp++;
                assert (gq.size() === eq.size()) else begin
                    n_fail++;
                    $error("FAIL %s dut%0d kind%0d count: got %0d, expected %0d",
                           tag, d, k, gq.size(), eq.size());
                end
                m = (gq.size() < eq.size()) ? gq.size() : eq.size();
                for (int i = 0; i < m; i++) begin
                    n_cmp++;
                    assert (gq[i] === eq[i]) else begin
                        n_fail++;
                        $error("FAIL %s dut%0d kind%0d item%0d: got cyc=%0d idx=%0d pc=%0d fv=%0d, expected cyc=%0d idx=%0d pc=%0d fv=%0d",
                               tag, d, k, i, gq[i].cyc, gq[i].idx, gq[i].pc, gq[i].fv,
                               eq[i].cyc, eq[i].idx, eq[i].pc, eq[i].fv);
                    end
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        logic [17:0] obs;
        for (int d = 0; d < 3; d++) begin
            obs = {busy_w[d], done_w[d], rd_en_w[d], fv_w[d], wr_en_w[d], pc_w[d],
                   rd_idx_w[d], wr_idx_w[d]};
            n_cmp++;
            assert (obs === 18'h0) else begin
                n_fail++;
                $error("FAIL %s dut%0d outputs: got %h, expected %h", tag, d, obs, 18'h0);
            end
        end
    endtask

    // Runs one frame per instance from start cycle s, optionally with spurious start pulses.
    task automatic frame_test(input string tag, input int hmode, input bit extra_starts);
        int s;
        int dc;
        int dmax;
        s    = cyc + 1;
        dmax = 0;
        set_hold(hmode, s);
        for (int d = 0; d < 3; d++) begin
            start_at[d][s] = 1'b1;
            if (extra_starts) begin
                start_at[d][s + 5]  = 1'b1;
                start_at[d][s + 80] = 1'b1;
                start_at[d][s + 2 * NV + 2 * lat_tab[d] + 1] = 1'b1;
            end
        end
        for (int d = 0; d < 3; d++) begin
            model_frame(d, s, dc);
            if (dc > dmax) dmax = dc;
        end
        while (cyc < dmax + 5) tick();
        check_all(tag);
    endtask

    initial begin
        int s;
        int d1 [3];
        int d2;
        int dmax;
        lat_tab = '{12, 1, 63};
        for (int d = 0; d < 3; d++) begin
            start_w[d]   = 1'b0;
            prev_busy[d] = 1'b0;
        end

        repeat (3) tick();
        check_quiet("reset_state");
        reset_i = 1'b0;
        repeat (2) tick();
        got_q.delete();

        frame_test("nohold", 0, 1'b0);
        frame_test("toggle_hold", 1, 1'b0);
        frame_test("random_hold", 2, 1'b0);
        frame_test("ignored_starts", 0, 1'b1);

        // Reset 40 cycles into the row pass.
        s = cyc + 1;
        set_hold(0, s);
        for (int d = 0; d < 3; d++) start_at[d][s] = 1'b1;
        while (cyc < s + 40) tick();
        #2;
        reset_i = 1'b1;
        #1;
        check_quiet("midframe_reset");
        repeat (3) tick();
        reset_i = 1'b0;
        got_q.delete();
        exp_q.delete();
        repeat (100) tick();
        check_all("post_reset_quiet");

        // Back-to-back frames: second start driven the cycle after the done pulse.
        s    = cyc + 1;
        dmax = 0;
        set_hold(0, s);
        for (int d = 0; d < 3; d++) begin
            start_at[d][s] = 1'b1;
            model_frame(d, s, d1[d]);
            start_at[d][d1[d] + 1] = 1'b1;
            model_frame(d, d1[d] + 1, d2);
            if (d2 > dmax) dmax = d2;
        end
        while (cyc < dmax + 5) tick();
        check_all("back_to_back");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
